// File: rtl/insertion_sort_stream_if.sv
// Stream interface for the insertion sorter: input word channel, output word
// channel and the per-frame order select.
interface insertion_sort_stream_if #(
  parameter int DATA_W = 32
);
  logic              descend;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Sorter side
  modport slave (
    input  descend, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer side
  modport master (
    output descend, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/insertion_sort_stream.sv
// Streaming insertion sorter: each accepted word is inserted into a sorted
// register array in the cycle it arrives, then the frame is streamed out
// smallest-first or largest-first as latched on the frame's first word.
module insertion_sort_stream #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  insertion_sort_stream_if.slave bus,
  output logic [CNT_W-1:0]      count,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  rd_q, rd_d;
  logic              desc_q, desc_d;
  logic [DEPTH-1:0]  prec;
  logic              accept;
  logic              mode;
  logic              frame_end;
  logic              rd_last;

  assign accept    = bus.in_valid && (state_q == LOAD) && !flush;
  // The order is taken live on the first word, then held for the frame.
  assign mode      = (count_q == '0) ? bus.descend : desc_q;
  assign frame_end = bus.in_last || (count_q == CNT_W'(DEPTH - 1));
  assign rd_last   = (rd_q == count_q - CNT_W'(1));

  // Flag held entries that stay ahead of the new word (ties keep the old word first)
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        prec[i] = mode ? (arr_q[i] >= bus.in_data) : (arr_q[i] <= bus.in_data);
      end else begin
        prec[i] = 1'b0;
      end
    end
  end

  // Next-state: flush first, then insertion in LOAD, read-out in DRAIN
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    desc_d  = desc_q;
    arr_d   = arr_q;
    if (flush) begin
      state_d = LOAD;
      count_d = '0;
      rd_d    = '0;
    end else if (state_q == LOAD) begin
      if (accept) begin
        if (count_q == '0) begin
          desc_d = bus.descend;
        end
        count_d = count_q + CNT_W'(1);
        // prec is a run of ones followed by zeros: the first zero is the
        // insertion slot, everything after it shifts up by one.
        if (!prec[0]) begin
          arr_d[0] = bus.in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (!prec[i]) begin
            arr_d[i] = prec[i-1] ? bus.in_data : arr_q[i-1];
          end
        end
        if (frame_end) begin
          state_d = DRAIN;
        end
      end
    end else if (bus.out_ready) begin
      if (rd_last) begin
        state_d = LOAD;
        count_d = '0;
        rd_d    = '0;
      end else begin
        rd_d = rd_q + CNT_W'(1);
      end
    end
  end

  // State, array and pointer registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      count_q <= '0;
      rd_q    <= '0;
      desc_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      desc_q  <= desc_d;
      arr_q   <= arr_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? arr_q[rd_q[IDX_W-1:0]] : '0;
  assign bus.out_last  = (state_q == DRAIN) && rd_last;
  assign count         = count_q;
  assign busy          = (state_q == DRAIN);

endmodule

// File: tb/tb_insertion_sort_stream.sv
// Directed bench for insertion_sort_stream with a queue-based reference
// model checked every cycle plus literal expected frames.
module tb_insertion_sort_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          busy;

  insertion_sort_stream_if #(.DATA_W(DW)) bus ();

  insertion_sort_stream #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: a frame is the list of accepted words, sorted as a whole
  bit              m_drain = 1'b0;
  bit              m_desc = 1'b0;
  int              m_rd = 0;
  logic [DW-1:0]   m_words[$];
  logic [DW-1:0]   m_sorted[$];
  logic [DW-1:0]   got[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_drain = 1'b0; m_rd = 0; m_words.delete(); m_sorted.delete();
      end else if (flush) begin
        m_drain = 1'b0; m_rd = 0; m_words.delete();
      end else if (!m_drain) begin
        if (bus.in_valid) begin
          if (m_words.size() == 0) m_desc = bus.descend;
          m_words.push_back(bus.in_data);
          if (bus.in_last || m_words.size() == DEPTH) begin
            m_sorted = m_words;
            if (m_desc) m_sorted.rsort();
            else        m_sorted.sort();
            m_drain = 1'b1;
          end
        end
      end else if (bus.out_ready) begin
        if (m_rd == m_sorted.size() - 1) begin
          m_drain = 1'b0; m_rd = 0; m_words.delete();
        end else begin
          m_rd++;
        end
      end
    end
  end

  // Every-cycle compare against the model, and capture of accepted outputs
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, !m_drain});
      chk("busy",      {31'd0, busy},          {31'd0, m_drain});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_drain});
      chk("count",     32'(count),             32'(m_words.size()));
      if (m_drain) begin
        chk("out_data", bus.out_data, m_sorted[m_rd]);
        chk("out_last", {31'd0, bus.out_last}, {31'd0, m_rd == m_sorted.size() - 1});
      end else begin
        chk("out_data_idle", bus.out_data, 32'd0);
        chk("out_last_idle", {31'd0, bus.out_last}, 32'd0);
      end
      if (bus.out_valid && bus.out_ready && !flush && rst_n) got.push_back(bus.out_data);
    end
  end

  task automatic push(input int d, input bit last, input bit desc);
    int k;
    bus.in_valid = 1'b1; bus.in_data = DW'(d); bus.in_last = last; bus.descend = desc;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) timeout("push");
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic drain(input int n, input bit toggle);
    int b;
    b = 0;
    while (got.size() < n && b < 200) begin
      bus.out_ready = toggle ? (b % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      b++;
    end
    bus.out_ready = 1'b0;
    if (b == 200) timeout("drain");
  endtask

  task automatic cmp_frame(input string name, input int exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) chk(name, got[i], 32'(exp[i]));
    end
    got.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[$];
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.descend = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_count",     32'(count),             32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Descending frame, explicit last, first output one cycle after last accept
    v = '{290, 255, 256, 270, 260, 258, 257, 300};
    got.delete();
    foreach (v[i]) push(v[i], i == v.size() - 1, 1'b1);
    chk("t1_latency", {31'd0, bus.out_valid}, 32'd1);
    drain(8, 1'b0);
    cmp_frame("t1", '{300, 290, 270, 260, 258, 257, 256, 255});
    @(posedge clk); #1;

    // Ascending frame with a stalling consumer
    v = '{42, 17, 93, 25, 51, 38, 64, 70};
    foreach (v[i]) push(v[i], i == v.size() - 1, 1'b0);
    drain(8, 1'b1);
    cmp_frame("t2", '{17, 25, 38, 42, 51, 64, 70, 93});
    @(posedge clk); #1;

    // Duplicates, no in_last: frame closes on the eighth word
    v = '{50, 50, 30, 70, 30, 70, 50, 30};
    foreach (v[i]) push(v[i], 1'b0, 1'b1);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    drain(8, 1'b0);
    cmp_frame("t3", '{70, 70, 50, 50, 50, 30, 30, 30});
    @(posedge clk); #1;

    // Short frame with descend toggled after the first word
    push(0, 1'b0, 1'b0);
    push(255, 1'b0, 1'b1);
    push(128, 1'b1, 1'b1);
    drain(3, 1'b0);
    cmp_frame("t4", '{0, 128, 255});
    @(posedge clk); #1;
    push(25, 1'b1, 1'b1);
    chk("t4_single_last", {31'd0, bus.out_last}, 32'd1);
    drain(1, 1'b0);
    cmp_frame("t4s", '{25});
    @(posedge clk); #1;

    // Flush mid-load, then mid-drain, then a clean frame
    push(5, 1'b0, 1'b0);
    push(3, 1'b0, 1'b0);
    push(9, 1'b0, 1'b0);
    do_flush();
    v = '{7, 1, 6, 2, 5, 3, 4, 0};
    foreach (v[i]) push(v[i], i == v.size() - 1, 1'b0);
    drain(2, 1'b0);
    cmp_frame("t5_part", '{0, 1});
    do_flush();
    push(11, 1'b0, 1'b1);
    push(10, 1'b0, 1'b1);
    push(12, 1'b1, 1'b1);
    drain(3, 1'b0);
    cmp_frame("t5", '{12, 11, 10});
    @(posedge clk); #1;

    // Asynchronous reset during drain, off the clock edge
    v = '{80, 10, 70, 20, 60, 30, 50, 40};
    foreach (v[i]) push(v[i], i == v.size() - 1, 1'b0);
    drain(3, 1'b0);
    cmp_frame("t6_part", '{10, 20, 30});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("arst_count",     32'(count),             32'd0);
    chk("arst_busy",      {31'd0, busy},          32'd0);
    chk("arst_out_data",  bus.out_data,           32'd0);
    chk("arst_out_last",  {31'd0, bus.out_last},  32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    v = '{3, 5, 1, 4, 2, 8, 7, 6};
    foreach (v[i]) push(v[i], i == v.size() - 1, 1'b1);
    drain(8, 1'b0);
    cmp_frame("t6", '{8, 7, 6, 5, 4, 3, 2, 1});
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/insertion_sort_stream.md
Name: insertion_sort_stream

Overview:
Parametrised streaming insertion sorter, successor to the fixed 8-input parallel sorter. Accepts a frame of up to DEPTH unsigned words serially over a valid/ready interface. Each word is inserted into a sorted register array in the cycle it is accepted. The sorted frame is then streamed out in ascending or descending order, selected per frame. Sits between a sample-capture stage and downstream consumers in the sorting datapath.

Parameters:
DATA_W, 32, width of each unsigned data word
DEPTH, 8, maximum frame length (>=2)
CNT_W, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort: discard frame, return to LOAD
descend  in  1  order select: 1 = largest first, 0 = smallest first; latched on first accepted word of a frame
in_valid  in  1  input word valid
in_ready  out  1  sorter can accept a word
in_data  in  DATA_W  input word
in_last  in  1  marks final word of a frame
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output word
out_data  out  DATA_W  sorted output word
out_last  out  1  marks final sorted word of a frame
count  out  CNT_W  words currently held
busy  out  1  high while in DRAIN state

Behaviour:
- Reset (rst_n low, async): state=LOAD; all array entries, count, rd_ptr and latched mode cleared to 0. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, count=0, busy=0.
- States: LOAD, DRAIN. in_ready = (state==LOAD). busy = (state==DRAIN).
- LOAD: on in_valid&in_ready, word is inserted in the same cycle and count increments.
  - Insert position p = number of held entries that precede the new word in the active order.
  - Entries at index >= p shift up one slot; new word is written at p.
  - Comparison is unsigned.
  - Ties are stable: a new word is placed after existing equal words.
  - Mode is latched when count==0 at acceptance; descend is ignored mid-frame.
- LOAD->DRAIN when the accepted word has in_last=1, or when count reaches DEPTH (implicit last). in_last on a word accepted with count==DEPTH-1 is the same event.
- DRAIN: out_valid=1, out_data=array[rd_ptr] (index 0 first), out_last=(rd_ptr==count-1).
  - On out_valid&out_ready, rd_ptr increments.
  - On handshake with out_last=1: state->LOAD, count=0, rd_ptr=0, out_valid drops the next cycle.
  - out_data/out_last are held stable while out_valid&!out_ready.
- Latency: first out_valid is the cycle after the last input handshake. Peak throughput is one word/cycle in and one word/cycle out. Input and output do not overlap; in_ready=0 throughout DRAIN.
- Single-word frame (in_last on the first word): DRAIN outputs one word with out_last=1.
- flush (synchronous, higher priority than any handshake in the same cycle): state=LOAD, count=0, rd_ptr=0, out_valid=0 next cycle. Array contents need not be cleared. Any word presented in that cycle is not accepted.
- Reset asserted mid-frame or mid-drain: immediate return to reset values; no partial output.
- in_valid while in DRAIN: ignored (in_ready=0); the upstream must hold its data.

Test Plan:
- DEPTH=8, descend=1; stream 290,255,256,270,260,258,257,300 with in_last on 300 -> out 300,290,270,260,258,257,256,255; out_last on 255; first out_valid 1 cycle after the last input accept.
- descend=0; stream 42,17,93,25,51,38,64,70 with out_ready toggling 1/0 -> out 17,25,38,42,51,64,70,93; data held stable during stalls; no drops or duplicates.
- Duplicates, descend=1: 50,50,30,70,30,70,50,30 -> 70,70,50,50,50,30,30,30; count=8 at the DRAIN transition with no in_last asserted (implicit last).
- Short frame: 0,255,128 (in_last on 128), descend=0 -> 0,128,255, out_last on 255. Then a one-word frame of 25 -> single output 25 with out_last=1. descend toggled mid-frame has no effect on order.
- flush asserted after 3 words accepted, and again mid-DRAIN -> count=0, out_valid=0, in_ready=1 next cycle; next frame sorts correctly with no leftover words.
- rst_n pulsed low asynchronously (off clock edge) during DRAIN -> outputs immediately at reset values; a subsequent full frame sorts correctly.
